// File: rtl/vga_sdram_arbiter_if.sv
// Bus bundle between the VGA reader, the pixel source, the SDRAM controller port and the arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface vga_sdram_arbiter_if #(
  parameter int AVS_DW          = 16,
  parameter int AVS_AW          = 23,
  parameter int MAX_OUTSTANDING = 4
);
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  logic              vga_read;
  logic [AVS_AW-1:0] vga_address;
  logic              vga_urgent;
  logic              vga_waitrequest;
  logic [AVS_DW-1:0] vga_readdata;
  logic              vga_readdatavalid;

  logic                src_read;
  logic                src_write;
  logic [AVS_AW-1:0]   src_address;
  logic [AVS_DW-1:0]   src_writedata;
  logic [AVS_DW/8-1:0] src_byteenable;
  logic                src_waitrequest;
  logic [AVS_DW-1:0]   src_readdata;
  logic                src_readdatavalid;

  logic                avs_read;
  logic                avs_write;
  logic [AVS_AW-1:0]   avs_address;
  logic [AVS_DW-1:0]   avs_writedata;
  logic [AVS_DW/8-1:0] avs_byteenable;
  logic [AVS_DW-1:0]   avs_readdata;
  logic                avs_waitrequest;
  logic                avs_readdatavalid;

  logic [CW-1:0] rd_outstanding;
  logic          rsp_err;

  modport slave (
    input  vga_read, vga_address, vga_urgent,
    output vga_waitrequest, vga_readdata, vga_readdatavalid,
    input  src_read, src_write, src_address, src_writedata, src_byteenable,
    output src_waitrequest, src_readdata, src_readdatavalid,
    output avs_read, avs_write, avs_address, avs_writedata, avs_byteenable,
    input  avs_readdata, avs_waitrequest, avs_readdatavalid,
    output rd_outstanding, rsp_err
  );

  modport master (
    output vga_read, vga_address, vga_urgent,
    input  vga_waitrequest, vga_readdata, vga_readdatavalid,
    output src_read, src_write, src_address, src_writedata, src_byteenable,
    input  src_waitrequest, src_readdata, src_readdatavalid,
    input  avs_read, avs_write, avs_address, avs_writedata, avs_byteenable,
    output avs_readdata, avs_waitrequest, avs_readdatavalid,
    input  rd_outstanding, rsp_err
  );
endinterface

// File: rtl/vga_sdram_arbiter.sv
// Two-master Avalon-MM arbiter (VGA reader V, pixel source S) with an in-order read tag FIFO.
// Optional S starvation guard against urgent V: define VGA_ARB_STARVE_GUARD_EN.
module vga_sdram_arbiter #(
  parameter int AVS_DW          = 16,
  parameter int AVS_AW          = 23,
`ifdef VGA_ARB_STARVE_GUARD_EN
  parameter int STARVE_MAX      = 8,
`endif
  parameter int MAX_OUTSTANDING = 4
) (
  input logic                sys_clk,
  input logic                sys_rst,
  vga_sdram_arbiter_if.slave bus
);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {GntNone, GntV, GntS} gnt_e;

  gnt_e                 gnt;
  logic                 last_s_q, last_s_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [MAX_OUTSTANDING-1:0] tag_q;
  logic                 rsp_err_q;
  logic                 rd_full, req_v, req_s, starve_force;
  logic                 acc_v, acc_s, push, pop, head;

  assign rd_full = (cnt_q == CW'(MAX_OUTSTANDING));
  assign req_v   = bus.vga_read & ~rd_full;
  assign req_s   = bus.src_write | (bus.src_read & ~rd_full);

`ifdef VGA_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q, starve_d;

  // Counts V accepts only while S keeps asking; saturates at STARVE_MAX.
  always_comb begin
    starve_d = starve_q;
    if (!req_s || acc_s) begin
      starve_d = '0;
    end else if (acc_v && (starve_q != SW'(STARVE_MAX))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) starve_q <= '0;
    else         starve_q <= starve_d;
  end

  assign starve_force = req_s & (starve_q == SW'(STARVE_MAX));
`else
  assign starve_force = 1'b0;
`endif

  // Grant: urgent V first, then round robin on last_s_q for ties.
  always_comb begin
    gnt = GntNone;
    if (req_v && bus.vga_urgent && !starve_force) begin
      gnt = GntV;
    end else if (req_s && (starve_force || !req_v || !last_s_q)) begin
      gnt = GntS;
    end else if (req_v) begin
      gnt = GntV;
    end
  end

  assign acc_v = (gnt == GntV) & ~bus.avs_waitrequest;
  assign acc_s = (gnt == GntS) & ~bus.avs_waitrequest;
  assign push  = bus.avs_read & ~bus.avs_waitrequest;
  assign pop   = bus.avs_readdatavalid & (cnt_q != '0);
  assign head  = tag_q[rd_ptr_q];

  // Next-state logic
  always_comb begin
    last_s_d = last_s_q;
    if (acc_v)      last_s_d = 1'b0;
    else if (acc_s) last_s_d = 1'b1;

    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      last_s_q  <= 1'b1;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tag_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      last_s_q <= last_s_d;
      cnt_q    <= cnt_d;
      if (push) begin
        tag_q[wr_ptr_q] <= (gnt == GntS);
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (bus.avs_readdatavalid && (cnt_q == '0)) rsp_err_q <= 1'b1;
    end
  end

  // Output logic
  always_comb begin
    bus.avs_read       = 1'b0;
    bus.avs_write      = 1'b0;
    bus.avs_address    = '0;
    bus.avs_writedata  = '0;
    bus.avs_byteenable = '0;
    case (gnt)
      GntV: begin
        bus.avs_read       = 1'b1;
        bus.avs_address    = bus.vga_address;
        bus.avs_byteenable = '1;
      end
      GntS: begin
        bus.avs_read       = bus.src_read;
        bus.avs_write      = bus.src_write;
        bus.avs_address    = bus.src_address;
        bus.avs_writedata  = bus.src_writedata;
        bus.avs_byteenable = bus.src_byteenable;
      end
      default: ;
    endcase
  end

  assign bus.vga_waitrequest   = ~acc_v;
  assign bus.src_waitrequest   = ~acc_s;
  assign bus.vga_readdata      = bus.avs_readdata;
  assign bus.src_readdata      = bus.avs_readdata;
  assign bus.vga_readdatavalid = pop & ~head;
  assign bus.src_readdatavalid = pop & head;
  assign bus.rd_outstanding    = cnt_q;
  assign bus.rsp_err           = rsp_err_q;
endmodule

// File: tb/tb_vga_sdram_arbiter.sv
// Bench for vga_sdram_arbiter: grant vector table, read-return scoreboard, corner-case sequences.
module tb_vga_sdram_arbiter;
  localparam int DW = 16;
  localparam int AW = 23;
  localparam int MO = 4;
`ifdef VGA_ARB_STARVE_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_sdram_arbiter_if #(.AVS_DW(DW), .AVS_AW(AW), .MAX_OUTSTANDING(MO)) bus ();

  vga_sdram_arbiter #(.AVS_DW(DW), .AVS_AW(AW), .MAX_OUTSTANDING(MO)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          own;   // 0 = V, 1 = S
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ctl_q[$];

  // grant code: 0 none, 1 V, 2 S
  typedef struct {
    logic     v_rd;
    logic     urg;
    logic     s_rd;
    logic     s_wr;
    logic     aw;
    int       g;
    logic     e_vw;
    logic     e_sw;
    int       e_cnt;
  } vec_t;

  vec_t tbl[11];

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'h5A3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_read(input logic own, input logic [AW-1:0] a);
    exp_t e;
    e.own  = own;
    e.data = mem(a);
    exp_q.push_back(e);
  endtask

  task automatic ret();
    if (ctl_q.size() > 0) begin
      bus.avs_readdatavalid = 1'b1;
      bus.avs_readdata      = ctl_q.pop_front();
    end
  endtask

  task automatic idle_inputs();
    bus.vga_read          = 1'b0;
    bus.vga_address       = '0;
    bus.vga_urgent        = 1'b0;
    bus.src_read          = 1'b0;
    bus.src_write         = 1'b0;
    bus.src_address       = '0;
    bus.src_writedata     = '0;
    bus.src_byteenable    = '0;
    bus.avs_readdata      = '0;
    bus.avs_waitrequest   = 1'b0;
    bus.avs_readdatavalid = 1'b0;
  endtask

  // Called at the negedge: check read routing, model controller accept, advance one cycle.
  task automatic tick();
    exp_t e;
    if (bus.avs_readdatavalid && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rdv_vga", bus.vga_readdatavalid, !e.own);
      chk("rdv_src", bus.src_readdatavalid, e.own);
      chk("rdata", e.own ? bus.src_readdata : bus.vga_readdata, e.data);
    end else begin
      chk("no_rdv_vga", bus.vga_readdatavalid, 0);
      chk("no_rdv_src", bus.src_readdatavalid, 0);
    end
    if (bus.avs_read && !bus.avs_waitrequest) ctl_q.push_back(mem(bus.avs_address));
    @(posedge clk);
    #1;
    bus.avs_readdatavalid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    exp_q.delete();
    ctl_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    //            v_rd urg s_rd s_wr aw g  vw sw cnt
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b1, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b1, 1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b0, 2};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b1, 1'b1, 2};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b0, 2};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b1, 2};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b1, 3};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b0, 4};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 4};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b1, 1'b0, 4};

    do_reset();

    // Reset idle
    @(negedge clk);
    chk("rst_avs_read", bus.avs_read, 0);
    chk("rst_avs_write", bus.avs_write, 0);
    chk("rst_vga_wait", bus.vga_waitrequest, 1);
    chk("rst_src_wait", bus.src_waitrequest, 1);
    chk("rst_outstanding", bus.rd_outstanding, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    tick();

    // Grant table: tie alternation, waitrequest, urgent, full blocking
    for (int i = 0; i < 11; i++) begin
      bus.vga_read        = tbl[i].v_rd;
      bus.vga_urgent      = tbl[i].urg;
      bus.vga_address     = AW'(32'h100 + i);
      bus.src_read        = tbl[i].s_rd;
      bus.src_write       = tbl[i].s_wr;
      bus.src_address     = AW'(32'h200 + i);
      bus.src_writedata   = DW'(32'hB000 + i);
      bus.src_byteenable  = 2'b01;
      bus.avs_waitrequest = tbl[i].aw;
      if (!tbl[i].aw) begin
        if (tbl[i].g == 1) exp_read(1'b0, bus.vga_address);
        else if (tbl[i].g == 2 && tbl[i].s_rd) exp_read(1'b1, bus.src_address);
      end
      @(negedge clk);
      chk($sformatf("vec%0d_avs_read", i), bus.avs_read,
          (tbl[i].g == 1) || (tbl[i].g == 2 && tbl[i].s_rd));
      chk($sformatf("vec%0d_avs_write", i), bus.avs_write, tbl[i].g == 2 && tbl[i].s_wr);
      if (tbl[i].g == 1) begin
        chk($sformatf("vec%0d_addr", i), bus.avs_address, 32'h100 + i);
        chk($sformatf("vec%0d_be", i), bus.avs_byteenable, 2'b11);
      end
      if (tbl[i].g == 2) begin
        chk($sformatf("vec%0d_addr", i), bus.avs_address, 32'h200 + i);
        chk($sformatf("vec%0d_be", i), bus.avs_byteenable, 2'b01);
        if (tbl[i].s_wr) chk($sformatf("vec%0d_wdata", i), bus.avs_writedata, 32'hB000 + i);
      end
      chk($sformatf("vec%0d_vga_wait", i), bus.vga_waitrequest, tbl[i].e_vw);
      chk($sformatf("vec%0d_src_wait", i), bus.src_waitrequest, tbl[i].e_sw);
      chk($sformatf("vec%0d_outstanding", i), bus.rd_outstanding, tbl[i].e_cnt);
      tick();
    end

    // Full: a pop this cycle does not release reads until the next cycle
    idle_inputs();
    bus.vga_read    = 1'b1;
    bus.vga_address = 23'h300;
    ret();
    @(negedge clk);
    chk("full_pop_still_stalled", bus.vga_waitrequest, 1);
    chk("full_pop_outstanding", bus.rd_outstanding, 4);
    tick();
    exp_read(1'b0, 23'h300);
    @(negedge clk);
    chk("full_resume_wait", bus.vga_waitrequest, 0);
    chk("full_resume_read", bus.avs_read, 1);
    chk("full_resume_outstanding", bus.rd_outstanding, 3);
    tick();
    bus.vga_read = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ret();
      @(negedge clk);
      tick();
    end
    @(negedge clk);
    chk("drain_outstanding", bus.rd_outstanding, 0);
    tick();

    // Routing: V@10, S@20, V@30 return D0,D1,D2
    bus.vga_read = 1'b1; bus.vga_address = 23'h10;
    exp_read(1'b0, 23'h10);
    @(negedge clk);
    chk("route_v0_wait", bus.vga_waitrequest, 0);
    tick();
    bus.vga_read = 1'b0; bus.src_read = 1'b1; bus.src_address = 23'h20;
    exp_read(1'b1, 23'h20);
    @(negedge clk);
    chk("route_s1_wait", bus.src_waitrequest, 0);
    tick();
    bus.src_read = 1'b0; bus.vga_read = 1'b1; bus.vga_address = 23'h30;
    exp_read(1'b0, 23'h30);
    @(negedge clk);
    chk("route_v2_wait", bus.vga_waitrequest, 0);
    tick();
    bus.vga_read = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ret();
      @(negedge clk);
      chk($sformatf("route_outstanding%0d", k), bus.rd_outstanding, 3 - k);
      tick();
    end
    @(negedge clk);
    chk("route_outstanding_end", bus.rd_outstanding, 0);
    tick();

    // Urgent V against reading S for 10 cycles, with same-cycle push/pop
    do_reset();
    for (int i = 0; i < 10; i++) begin
      logic sg;
      sg = Guard && (i == 8);
      bus.vga_read    = 1'b1;
      bus.vga_urgent  = 1'b1;
      bus.vga_address = AW'(32'h40 + i);
      bus.src_read    = 1'b1;
      bus.src_address = 23'h80;
      ret();
      if (sg) exp_read(1'b1, 23'h80);
      else    exp_read(1'b0, bus.vga_address);
      @(negedge clk);
      chk($sformatf("urg%0d_vga_wait", i), bus.vga_waitrequest, sg);
      chk($sformatf("urg%0d_src_wait", i), bus.src_waitrequest, !sg);
      tick();
    end
    idle_inputs();
    for (int k = 0; k < 8 && ctl_q.size() > 0; k++) begin
      ret();
      @(negedge clk);
      tick();
    end
    @(negedge clk);
    chk("urg_outstanding_end", bus.rd_outstanding, 0);
    chk("urg_no_err", bus.rsp_err, 0);
    tick();

    // Error: readdatavalid with nothing outstanding
    bus.avs_readdatavalid = 1'b1;
    bus.avs_readdata      = 16'hDEAD;
    @(negedge clk);
    chk("err_no_vga_rdv", bus.vga_readdatavalid, 0);
    chk("err_no_src_rdv", bus.src_readdatavalid, 0);
    tick();
    @(negedge clk);
    chk("err_set", bus.rsp_err, 1);
    chk("err_outstanding", bus.rd_outstanding, 0);
    tick();
    repeat (3) begin
      @(negedge clk);
      tick();
    end
    @(negedge clk);
    chk("err_sticky", bus.rsp_err, 1);
    do_reset();
    @(negedge clk);
    chk("err_cleared", bus.rsp_err, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
